// File: rtl/sdi_reconfig_pkg.sv
// Shared types and the per-rate read-modify-write table for the SDI line-rate
// reconfiguration controller.
package sdi_reconfig_pkg;

  localparam int ENTRIES = 4;
  localparam int IDX_W   = $clog2(ENTRIES);

  typedef enum logic [1:0] {
    HD  = 2'd0,
    G3  = 2'd1,
    G6  = 2'd2,
    G12 = 2'd3
  } sdi_rate_e;

  typedef struct packed {
    logic [14:0] addr;
    logic [31:0] mask;
    logic [31:0] value;
  } rmw_entry_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_ON,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_NEXT,
    S_RST_OFF,
    S_LOCK_WAIT,
    S_FAIL
  } ctrl_state_e;

  // Same register set for every rate; only the field values change.
  localparam rmw_entry_t RMW_TABLE [4][ENTRIES] = '{
    '{ '{15'h0110, 32'h0000_00E0, 32'h0000_0000},
       '{15'h0124, 32'h0000_000F, 32'h0000_0003},
       '{15'h0138, 32'h0000_FF00, 32'h0000_2000},
       '{15'h0160, 32'h0000_0003, 32'h0000_0000} },
    '{ '{15'h0110, 32'h0000_00E0, 32'h0000_0040},
       '{15'h0124, 32'h0000_000F, 32'h0000_0005},
       '{15'h0138, 32'h0000_FF00, 32'h0000_1000},
       '{15'h0160, 32'h0000_0003, 32'h0000_0001} },
    '{ '{15'h0110, 32'h0000_00E0, 32'h0000_0080},
       '{15'h0124, 32'h0000_000F, 32'h0000_0008},
       '{15'h0138, 32'h0000_FF00, 32'h0000_0800},
       '{15'h0160, 32'h0000_0003, 32'h0000_0002} },
    '{ '{15'h0110, 32'h0000_00E0, 32'h0000_00C0},
       '{15'h0124, 32'h0000_000F, 32'h0000_000C},
       '{15'h0138, 32'h0000_FF00, 32'h0000_0400},
       '{15'h0160, 32'h0000_0003, 32'h0000_0003} }
  };

  function automatic logic [31:0] rmwMerge(input logic [31:0] readData,
                                           input rmw_entry_t entry);
    return (readData & ~entry.mask) | (entry.value & entry.mask);
  endfunction

endpackage

// File: rtl/sdi_lock_qualifier.sv
// Qualifies PLL lock: requires STABLE consecutive locked samples, and flags a
// timeout once TIMEOUT wait cycles have elapsed without qualification.
module sdi_lock_qualifier #(
  parameter int STABLE  = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  input  logic pll_locked_i,
  output logic qualified_o,
  output logic timeout_o
);

  localparam int STABLE_W = $clog2(STABLE + 1);
  localparam int WAIT_W   = $clog2(TIMEOUT + 1);

  logic [STABLE_W-1:0] stableCnt_q, stableCnt_d;
  logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;

  always_comb begin
    stableCnt_d = stableCnt_q;
    waitCnt_d   = waitCnt_q;
    if (clear_i) begin
      stableCnt_d = '0;
      waitCnt_d   = '0;
    end else if (enable_i) begin
      stableCnt_d = pll_locked_i ? stableCnt_q + 1'b1 : '0;
      waitCnt_d   = waitCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stableCnt_q <= '0;
      waitCnt_q   <= '0;
    end else begin
      stableCnt_q <= stableCnt_d;
      waitCnt_q   <= waitCnt_d;
    end
  end

  // Both flags look at the current sample so the controller reacts on the
  // same edge that completes the count.
  assign qualified_o = enable_i && pll_locked_i &&
                       (stableCnt_q == STABLE_W'(STABLE - 1));
  assign timeout_o   = enable_i && (waitCnt_q == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/sdi_rate_reconfig_ctrl.sv
// Sequences an SDI line-rate change: holds the channel in reset, applies the
// per-rate register RMW table over Avalon-MM, then waits for qualified lock.
module sdi_rate_reconfig_ctrl
  import sdi_reconfig_pkg::*;
#(
  parameter int RD_TIMEOUT   = 1024,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int LOCK_STABLE  = 16
) (
  input  logic        clk_100_clk,
  input  logic        reset_100_reset,
  input  logic [1:0]  rate_req,
  input  logic        rate_req_valid,
  output logic        rate_req_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  cur_rate,
  output logic        xcvr_reset_req,
  input  logic        pll_locked,
  output logic [14:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest
);

  localparam int RD_CNT_W = $clog2(RD_TIMEOUT + 1);

  ctrl_state_e           state_q, state_d;
  sdi_rate_e             rate_q, rate_d;
  sdi_rate_e             curRate_q, curRate_d;
  logic [IDX_W-1:0]      entryIdx_q, entryIdx_d;
  logic [RD_CNT_W-1:0]   rdCnt_q, rdCnt_d;
  logic [31:0]           wrData_q, wrData_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  rmw_entry_t            curEntry;
  logic                  lockQualified;
  logic                  lockTimeout;

  assign curEntry = RMW_TABLE[rate_q][entryIdx_q];

  sdi_lock_qualifier #(
    .STABLE  (LOCK_STABLE),
    .TIMEOUT (LOCK_TIMEOUT)
  ) u_lock_qualifier (
    .clk_i        (clk_100_clk),
    .rst_i        (reset_100_reset),
    .clear_i      (state_q == S_RST_OFF),
    .enable_i     (state_q == S_LOCK_WAIT),
    .pll_locked_i (pll_locked),
    .qualified_o  (lockQualified),
    .timeout_o    (lockTimeout)
  );

  always_comb begin
    state_d    = state_q;
    rate_d     = rate_q;
    curRate_d  = curRate_q;
    entryIdx_d = entryIdx_q;
    rdCnt_d    = rdCnt_q;
    wrData_d   = wrData_q;
    done_d     = 1'b0;
    error_d    = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (rate_req_valid) begin
          rate_d     = sdi_rate_e'(rate_req);
          error_d    = 1'b0;
          entryIdx_d = '0;
          state_d    = S_RST_ON;
        end
      end
      S_RST_ON: state_d = S_RD_REQ;
      S_RD_REQ: begin
        if (!avm_waitrequest) begin
          rdCnt_d = '0;
          state_d = S_RD_WAIT;
        end
      end
      // Read-response timeout is measured from the cycle after the accept.
      S_RD_WAIT: begin
        if (avm_readdatavalid) begin
          wrData_d = rmwMerge(avm_readdata, curEntry);
          state_d  = S_WR_REQ;
        end else if (rdCnt_q == RD_CNT_W'(RD_TIMEOUT - 1)) begin
          state_d = S_FAIL;
        end else begin
          rdCnt_d = rdCnt_q + 1'b1;
        end
      end
      S_WR_REQ: begin
        if (!avm_waitrequest) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (entryIdx_q == IDX_W'(ENTRIES - 1)) begin
          state_d = S_RST_OFF;
        end else begin
          entryIdx_d = entryIdx_q + 1'b1;
          state_d    = S_RD_REQ;
        end
      end
      S_RST_OFF: state_d = S_LOCK_WAIT;
      S_LOCK_WAIT: begin
        if (lockQualified) begin
          done_d    = 1'b1;
          curRate_d = rate_q;
          state_d   = S_IDLE;
        end else if (lockTimeout) begin
          state_d = S_FAIL;
        end
      end
      S_FAIL: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100_clk) begin
    if (reset_100_reset) begin
      state_q    <= S_IDLE;
      rate_q     <= HD;
      curRate_q  <= HD;
      entryIdx_q <= '0;
      rdCnt_q    <= '0;
      wrData_q   <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rate_q     <= rate_d;
      curRate_q  <= curRate_d;
      entryIdx_q <= entryIdx_d;
      rdCnt_q    <= rdCnt_d;
      wrData_q   <= wrData_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Bus outputs decode straight from state so an abandoned command drops on
  // the same edge that resets the FSM.
  assign rate_req_ready = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign error          = error_q;
  assign cur_rate       = curRate_q;
  assign xcvr_reset_req = (state_q == S_RST_ON)  || (state_q == S_RD_REQ) ||
                          (state_q == S_RD_WAIT) || (state_q == S_WR_REQ) ||
                          (state_q == S_NEXT);
  assign avm_read       = (state_q == S_RD_REQ);
  assign avm_write      = (state_q == S_WR_REQ);
  assign avm_address    = (avm_read || avm_write) ? curEntry.addr : '0;
  assign avm_writedata  = avm_write ? wrData_q : '0;
  assign avm_byteenable = 4'hF;

endmodule

// File: tb/tb_sdi_rate_reconfig_ctrl.sv
// Directed self-checking bench for sdi_rate_reconfig_ctrl with a small
// Avalon-MM slave model that logs every accepted read and write.
module tb_sdi_rate_reconfig_ctrl;

  localparam int RD_TO   = 32;
  localparam int LOCK_TO = 200;
  localparam int STABLE  = 16;

  logic        clk_100_clk = 1'b0;
  logic        reset_100_reset = 1'b1;
  logic [1:0]  rate_req = 2'd0;
  logic        rate_req_valid = 1'b0;
  logic        rate_req_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  cur_rate;
  logic        xcvr_reset_req;
  logic        pll_locked = 1'b0;
  logic [14:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b0;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int acceptCycle = 0;
  int riseCycle = 0;

  // Slave model knobs (written by the stimulus block only)
  int          waitCycles = 0;
  int          rdLatency = 1;
  logic        suppressValid = 1'b0;
  logic        spuriousValid = 1'b0;
  logic [31:0] readdataVal = 32'hFFFF_FFFF;

  // Slave model observations (written by the slave model only)
  int          rdCount = 0;
  int          wrCount = 0;
  int          doneCount = 0;
  int          doneCycle = 0;
  int          bothHigh = 0;
  int          stableViol = 0;
  logic [14:0] wrAddrLog [64];
  logic [31:0] wrDataLog [64];

  sdi_rate_reconfig_ctrl #(
    .RD_TIMEOUT   (RD_TO),
    .LOCK_TIMEOUT (LOCK_TO),
    .LOCK_STABLE  (STABLE)
  ) dut (
    .clk_100_clk       (clk_100_clk),
    .reset_100_reset   (reset_100_reset),
    .rate_req          (rate_req),
    .rate_req_valid    (rate_req_valid),
    .rate_req_ready    (rate_req_ready),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .cur_rate          (cur_rate),
    .xcvr_reset_req    (xcvr_reset_req),
    .pll_locked        (pll_locked),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest)
  );

  initial forever #5 clk_100_clk = ~clk_100_clk;

  always @(posedge clk_100_clk) cycle <= cycle + 1;

  // Avalon-MM slave model: responds on the falling edge so the DUT samples
  // settled waitrequest/readdatavalid on the next rising edge.
  initial begin
    int          waitCnt;
    int          pending;
    logic        rv;
    logic [14:0] heldAddr;
    logic [31:0] heldData;
    logic        heldRead;
    waitCnt = 0;
    pending = 0;
    heldAddr = '0;
    heldData = '0;
    heldRead = 1'b0;
    forever begin
      @(negedge clk_100_clk);
      if (done) begin
        doneCount = doneCount + 1;
        doneCycle = cycle;
      end
      if (avm_read && avm_write) bothHigh = bothHigh + 1;
      if (reset_100_reset) begin
        waitCnt = 0;
        pending = 0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = spuriousValid;
      end else begin
        rv = 1'b0;
        if (pending > 0) begin
          pending = pending - 1;
          if (pending == 0 && !suppressValid) rv = 1'b1;
        end
        avm_readdatavalid = rv | spuriousValid;
        avm_readdata = readdataVal;
        if (avm_read || avm_write) begin
          if (avm_waitrequest &&
              (avm_address !== heldAddr || avm_writedata !== heldData ||
               avm_read !== heldRead))
            stableViol = stableViol + 1;
          heldAddr = avm_address;
          heldData = avm_writedata;
          heldRead = avm_read;
          if (waitCnt < waitCycles) begin
            avm_waitrequest = 1'b1;
            waitCnt = waitCnt + 1;
          end else begin
            avm_waitrequest = 1'b0;
            waitCnt = 0;
            if (avm_read) begin
              rdCount = rdCount + 1;
              pending = rdLatency;
            end else begin
              wrAddrLog[wrCount % 64] = avm_address;
              wrDataLog[wrCount % 64] = avm_writedata;
              wrCount = wrCount + 1;
            end
          end
        end else begin
          avm_waitrequest = 1'b0;
          waitCnt = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected)
    else begin
      errors = errors + 1;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issues a one-cycle request; returns in the first cycle after acceptance.
  task automatic applyStimulus(input logic [1:0] rate);
    @(negedge clk_100_clk);
    rate_req = rate;
    rate_req_valid = 1'b1;
    @(negedge clk_100_clk);
    rate_req_valid = 1'b0;
    acceptCycle = cycle;
  endtask

  task automatic waitReady(input string tag, input int budget);
    for (int n = 0; n < budget && !rate_req_ready; n++) @(negedge clk_100_clk);
    checkOutput(tag, 32'(rate_req_ready), 32'd1);
  endtask

  initial begin
    int rd0, wr0, dn0;

    // Reset values
    repeat (3) @(negedge clk_100_clk);
    checkOutput("rst_ready_in_reset", 32'(rate_req_ready), 32'd1);
    reset_100_reset = 1'b0;
    @(negedge clk_100_clk);
    checkOutput("rst_ready", 32'(rate_req_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_cur_rate", 32'(cur_rate), 32'd0);
    checkOutput("rst_xcvr", 32'(xcvr_reset_req), 32'd0);
    checkOutput("rst_rd_wr", {30'd0, avm_read, avm_write}, 32'd0);
    checkOutput("rst_addr", 32'(avm_address), 32'd0);
    checkOutput("rst_wdata", avm_writedata, 32'd0);
    checkOutput("rst_be", 32'(avm_byteenable), 32'hF);

    // G3 basic sequence, all-ones readback, immediate lock
    $display("[TB] G3 basic sequence");
    pll_locked = 1'b1;
    rd0 = rdCount; wr0 = wrCount; dn0 = doneCount;
    applyStimulus(2'd1);
    checkOutput("g3_rst_on_xcvr", 32'(xcvr_reset_req), 32'd1);
    checkOutput("g3_rst_on_read", 32'(avm_read), 32'd0);
    checkOutput("g3_rst_on_busy", 32'(busy), 32'd1);
    @(negedge clk_100_clk);
    checkOutput("g3_first_read", 32'(avm_read), 32'd1);
    checkOutput("g3_first_addr", 32'(avm_address), 32'h0110);
    rate_req = 2'd2;
    rate_req_valid = 1'b1;
    @(negedge clk_100_clk);
    checkOutput("g3_ready_busy", 32'(rate_req_ready), 32'd0);
    rate_req_valid = 1'b0;
    waitReady("g3_finish", 200);
    checkOutput("g3_done_pulse", 32'(done), 32'd1);
    checkOutput("g3_done_latency", 32'(doneCycle - acceptCycle), 32'd34);
    checkOutput("g3_wr0_addr", 32'(wrAddrLog[wr0 % 64]), 32'h0110);
    checkOutput("g3_wr0_data", wrDataLog[wr0 % 64], 32'hFFFF_FF5F);
    checkOutput("g3_wr1_data", wrDataLog[(wr0 + 1) % 64], 32'hFFFF_FFF5);
    checkOutput("g3_wr2_data", wrDataLog[(wr0 + 2) % 64], 32'hFFFF_10FF);
    checkOutput("g3_wr3_addr", 32'(wrAddrLog[(wr0 + 3) % 64]), 32'h0160);
    checkOutput("g3_wr3_data", wrDataLog[(wr0 + 3) % 64], 32'hFFFF_FFFD);
    @(negedge clk_100_clk);
    checkOutput("g3_done_one_cycle", 32'(done), 32'd0);
    checkOutput("g3_reads", 32'(rdCount - rd0), 32'd4);
    checkOutput("g3_writes", 32'(wrCount - wr0), 32'd4);
    checkOutput("g3_done_count", 32'(doneCount - dn0), 32'd1);
    checkOutput("g3_cur_rate", 32'(cur_rate), 32'd1);

    // Read response never arrives
    $display("[TB] read timeout");
    suppressValid = 1'b1;
    applyStimulus(2'd2);
    repeat (34) @(negedge clk_100_clk);
    checkOutput("rdto_fail_busy", 32'(busy), 32'd1);
    checkOutput("rdto_fail_xcvr", 32'(xcvr_reset_req), 32'd0);
    checkOutput("rdto_error_early", 32'(error), 32'd0);
    @(negedge clk_100_clk);
    checkOutput("rdto_error", 32'(error), 32'd1);
    checkOutput("rdto_idle", 32'(rate_req_ready), 32'd1);
    checkOutput("rdto_xcvr", 32'(xcvr_reset_req), 32'd0);
    checkOutput("rdto_cur_rate", 32'(cur_rate), 32'd1);
    suppressValid = 1'b0;

    // Lock never comes; request also clears the earlier error on accept
    $display("[TB] lock timeout");
    pll_locked = 1'b0;
    dn0 = doneCount;
    applyStimulus(2'd0);
    checkOutput("lkto_error_cleared", 32'(error), 32'd0);
    repeat (218) @(negedge clk_100_clk);
    checkOutput("lkto_error_early", 32'(error), 32'd0);
    checkOutput("lkto_busy_fail", 32'(busy), 32'd1);
    @(negedge clk_100_clk);
    checkOutput("lkto_error", 32'(error), 32'd1);
    checkOutput("lkto_idle", 32'(rate_req_ready), 32'd1);
    checkOutput("lkto_cur_rate", 32'(cur_rate), 32'd1);
    checkOutput("lkto_no_done", 32'(doneCount - dn0), 32'd0);

    // Lock drops after 10 stable samples and must restart the count
    $display("[TB] lock glitch");
    dn0 = doneCount;
    applyStimulus(2'd0);
    checkOutput("glitch_error_cleared", 32'(error), 32'd0);
    for (int n = 0; n < 100 && xcvr_reset_req; n++) @(negedge clk_100_clk);
    checkOutput("glitch_rst_off", 32'(cycle - acceptCycle), 32'd17);
    @(negedge clk_100_clk);
    pll_locked = 1'b1;
    repeat (10) @(negedge clk_100_clk);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk_100_clk);
    pll_locked = 1'b1;
    riseCycle = cycle;
    waitReady("glitch_finish", 100);
    checkOutput("glitch_done_delay", 32'(doneCycle - riseCycle), 32'd16);
    checkOutput("glitch_done_count", 32'(doneCount - dn0), 32'd1);
    checkOutput("glitch_cur_rate", 32'(cur_rate), 32'd0);

    // Waitrequest held 5 cycles per command, slower read response
    $display("[TB] G12 with waitrequest");
    waitCycles = 5;
    rdLatency = 3;
    readdataVal = 32'h1234_5678;
    rd0 = rdCount; wr0 = wrCount; dn0 = doneCount;
    applyStimulus(2'd3);
    waitReady("g12_finish", 400);
    checkOutput("g12_reads", 32'(rdCount - rd0), 32'd4);
    checkOutput("g12_writes", 32'(wrCount - wr0), 32'd4);
    checkOutput("g12_wr0_data", wrDataLog[wr0 % 64], 32'h1234_56D8);
    checkOutput("g12_wr1_data", wrDataLog[(wr0 + 1) % 64], 32'h1234_567C);
    checkOutput("g12_wr2_addr", 32'(wrAddrLog[(wr0 + 2) % 64]), 32'h0138);
    checkOutput("g12_wr2_data", wrDataLog[(wr0 + 2) % 64], 32'h1234_0478);
    checkOutput("g12_wr3_data", wrDataLog[(wr0 + 3) % 64], 32'h1234_567B);
    checkOutput("g12_stable", 32'(stableViol), 32'd0);
    checkOutput("g12_done_count", 32'(doneCount - dn0), 32'd1);
    checkOutput("g12_cur_rate", 32'(cur_rate), 32'd3);

    // Reset while a write is stalled
    $display("[TB] reset during write");
    applyStimulus(2'd1);
    for (int n = 0; n < 200 && !avm_write; n++) @(negedge clk_100_clk);
    checkOutput("mid_write_seen", 32'(avm_write), 32'd1);
    reset_100_reset = 1'b1;
    @(negedge clk_100_clk);
    checkOutput("mid_rst_write", 32'(avm_write), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_ready", 32'(rate_req_ready), 32'd1);
    checkOutput("mid_rst_cur_rate", 32'(cur_rate), 32'd0);
    checkOutput("mid_rst_xcvr", 32'(xcvr_reset_req), 32'd0);
    reset_100_reset = 1'b0;
    waitCycles = 0;
    rdLatency = 1;
    @(negedge clk_100_clk);
    spuriousValid = 1'b1;
    @(negedge clk_100_clk);
    spuriousValid = 1'b0;
    repeat (2) @(negedge clk_100_clk);
    checkOutput("spurious_busy", 32'(busy), 32'd0);
    checkOutput("spurious_cmds", {30'd0, avm_read, avm_write}, 32'd0);
    checkOutput("spurious_ready", 32'(rate_req_ready), 32'd1);

    // Same rate as current still runs the full table
    $display("[TB] repeat HD after reset");
    readdataVal = 32'h0000_0000;
    wr0 = wrCount; dn0 = doneCount;
    applyStimulus(2'd0);
    waitReady("hd_finish", 200);
    checkOutput("hd_writes", 32'(wrCount - wr0), 32'd4);
    checkOutput("hd_wr2_data", wrDataLog[(wr0 + 2) % 64], 32'h0000_2000);
    checkOutput("hd_done_count", 32'(doneCount - dn0), 32'd1);

    checkOutput("never_rd_and_wr", 32'(bothHigh), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdi_rate_reconfig_ctrl.md
# sdi_rate_reconfig_ctrl

Sequences a line-rate change (HD / 3G / 6G / 12G SDI) on the single-channel SDI transceiver. It acts as the Avalon-MM master on the transceiver subsystem's memory-mapped bridge and performs a fixed table of read-modify-write register updates per rate. Around those updates it holds the channel in reset, then qualifies PLL lock before reporting done. It sits in the 100 MHz control domain between the SDI rate-detect/host logic and the transceiver system's bridge slave.

## Interface
- `ENTRIES`, 4: RMW entries per rate.
- `RD_TIMEOUT`, 1024: max cycles from read accept to `readdatavalid`.
- `LOCK_TIMEOUT`, 100000: max cycles waiting for qualified lock.
- `LOCK_STABLE`, 16: consecutive `pll_locked` cycles required.

Ports:
- `clk_100_clk` in 1: the only clock.
- `reset_100_reset` in 1: synchronous, active-high reset.
- `rate_req` in 2: requested rate. 0=HD, 1=3G, 2=6G, 3=12G.
- `rate_req_valid` in 1: request strobe.
- `rate_req_ready` out 1: high only in IDLE.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse on success.
- `error` out 1: sticky failure flag. Cleared on the next accepted request.
- `cur_rate` out 2: last successfully applied rate.
- `xcvr_reset_req` out 1: channel reset request to the transceiver reset logic.
- `pll_locked` in 1: transceiver PLL lock.
- `avm_address` out 15: Avalon-MM master address.
- `avm_read` out 1, `avm_write` out 1: Avalon-MM master commands.
- `avm_writedata` out 32, `avm_byteenable` out 4: write data and byte enables.
- `avm_readdata` in 32, `avm_readdatavalid` in 1, `avm_waitrequest` in 1: Avalon-MM responses.

## Operation
- Reset values:
  - `rate_req_ready`=1.
  - `busy`, `done`, `error`, `xcvr_reset_req`, `avm_read`, `avm_write` = 0.
  - `avm_address`, `avm_writedata` = 0.
  - `avm_byteenable` = 4'hF (constant).
  - `cur_rate` = 0 (HD).
- States: IDLE, RST_ON, RD_REQ, RD_WAIT, WR_REQ, NEXT, RST_OFF, LOCK_WAIT, FAIL.
- IDLE: on `rate_req_valid`, latch `rate_req`, clear `error`, set entry index i=0, go to RST_ON.
- RST_ON: assert `xcvr_reset_req` (held through RST_OFF entry). Go to RD_REQ.
- RD_REQ: drive `avm_read`=1 and `avm_address`=table[rate][i].addr.
  - Hold both until a cycle with `avm_waitrequest`=0, then go to RD_WAIT.
- RD_WAIT: on `avm_readdatavalid`, compute `(readdata & ~mask) | (value & mask)` and go to WR_REQ.
  - No valid within `RD_TIMEOUT` cycles of the read accept → FAIL.
- WR_REQ: drive `avm_write`=1 with address and data held stable until `avm_waitrequest`=0, then go to NEXT.
- NEXT: if i==ENTRIES-1, go to RST_OFF; else i++ and go to RD_REQ.
- RST_OFF: deassert `xcvr_reset_req`, clear the lock counters, go to LOCK_WAIT.
- LOCK_WAIT: a stable counter increments while `pll_locked`=1 and resets to 0 on any low cycle.
  - Counter reaches `LOCK_STABLE` → pulse `done`, update `cur_rate`, go to IDLE.
  - Total wait reaches `LOCK_TIMEOUT` → FAIL.
- FAIL: set `error`, deassert `xcvr_reset_req`, go to IDLE. `cur_rate` unchanged.
- Boundary conditions:
  - Requests outside IDLE are ignored; `rate_req_ready`=0 there.
  - `readdatavalid` in any state other than RD_WAIT is ignored.
  - Reset mid-sequence returns all outputs to reset values on the next edge and abandons any in-flight transaction.
  - A request for the rate equal to `cur_rate` still runs the full sequence.
- Waitrequest is not timed out; the bridge guarantees progress.

## Timing
- Request accept to first `avm_read`: 2 cycles (RST_ON, then RD_REQ).
- Per entry with zero waitrequest and readdatavalid N cycles after accept: N + 3 cycles.
- `done` is asserted in the cycle after the `LOCK_STABLE`-th consecutive locked cycle is sampled; `busy` falls in that same cycle.
- `avm_read` and `avm_write` are never high together. Each command is one transfer (burstcount 1).

## Structure
- Package `sdi_reconfig_pkg` holds:
  - Rate enum `sdi_rate_e` (HD, G3, G6, G12).
  - Struct `rmw_entry_t` {addr[14:0], mask[31:0], value[31:0]}.
  - Constant `RMW_TABLE[4][ENTRIES]`.
  - State enum.
- Table entry 0 for G3 is addr 15'h0110, mask 32'h0000_00E0, value 32'h0000_0040.
- One sub-module, `sdi_lock_qualifier`: stable-lock counter plus timeout counter, with outputs `qualified` and `timeout`.

## Test plan
- Request G3, `readdata`=32'hFFFF_FFFF on all reads, waitrequest 0, `pll_locked`=1 → first write to 15'h0110 with data 32'hFFFF_FF5F. Exactly 4 reads and 4 writes, one `done` pulse, `cur_rate`=1.
- Hold `avm_waitrequest` high 5 cycles on each read and write → address and data stay stable throughout, each command is issued once, and the sequence completes.
- Toggle `pll_locked` low at stable count 10 → counter restarts, and `done` comes exactly `LOCK_STABLE` cycles after the final rising edge.
- Never assert `readdatavalid` → `error`=1 after `RD_TIMEOUT` cycles, `xcvr_reset_req`=0, IDLE, `cur_rate` unchanged.
- Keep `pll_locked`=0 → `error` at `LOCK_TIMEOUT`. The next request clears `error` on accept.
- Assert `reset_100_reset` during WR_REQ → the next cycle shows `avm_write`=0, `busy`=0, `rate_req_ready`=1, `cur_rate`=0. A spurious later `readdatavalid` is ignored.
